// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_pkg
// Description : Shared RV32I encode/decode constants: request opcode enum,
//               major opcodes, funct3/funct7 values and instruction formats.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

  // Request operation codes accepted by the encoder (5-bit request field)
  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_SLL   = 5'd5,
    OP_SRL   = 5'd6,
    OP_SRA   = 5'd7,
    OP_ADDI  = 5'd8,
    OP_ANDI  = 5'd9,
    OP_ORI   = 5'd10,
    OP_XORI  = 5'd11,
    OP_LW    = 5'd12,
    OP_SW    = 5'd13,
    OP_BEQ   = 5'd14,
    OP_BNE   = 5'd15,
    OP_LUI   = 5'd16,
    OP_AUIPC = 5'd17,
    OP_JAL   = 5'd18,
    OP_JALR  = 5'd19
  } enc_op_e;

  // Instruction formats, selecting immediate placement
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Major opcodes (shared with the core decoder)
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_JALR    = 3'b000;

  // funct7 values (ALT selects SUB / SRA)
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage : instr_encoder_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, power-of-two depth, with synchronous
//               clear. Push while full and pop while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  // Clear dominates; otherwise only legal push/pop take effect
  assign do_push = i_push && !o_full  && !i_clr;
  assign do_pop  = i_pop  && !o_empty && !i_clr;

  // Next-state pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_wdata;
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Encodes instruction requests into RV32I words, range-checks
//               immediates, buffers legal words and streams them into IMEM
//               at consecutive word addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [4:0]              i_op,
  input  logic [4:0]              i_rd,
  input  logic [4:0]              i_rs1,
  input  logic [4:0]              i_rs2,
  input  logic [31:0]             i_imm,
  input  logic [ADDR_W-1:0]       i_base,
  input  logic                    i_flush,
  output logic                    o_wr_en,
  input  logic                    i_wr_ready,
  output logic [ADDR_W-1:0]       o_wr_addr,
  output logic [31:0]             o_wr_data,
  output logic                    o_err,
  output logic [$clog2(DEPTH):0]  o_count
);

  fmt_e        fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        op_known;
  logic        imm_ok;
  logic        legal;
  logic [31:0] word;

  logic        fit12, fit13, fit21;
  logic        accept, push, pop;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_rdata;

  logic [ADDR_W-1:0] base_aligned;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              err_q, err_d;

  // Signed-range checks: upper bits must be a pure sign extension
  assign fit12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign fit13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign fit21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

  // Map request op to format, opcode and function fields
  always_comb begin
    fmt      = FMT_R;
    opc      = '0;
    f3       = '0;
    f7       = F7_BASE;
    op_known = 1'b1;
    case (i_op)
      OP_ADD:   begin opc = OPC_OP; f3 = F3_ADD_SUB; end
      OP_SUB:   begin opc = OPC_OP; f3 = F3_ADD_SUB; f7 = F7_ALT; end
      OP_AND:   begin opc = OPC_OP; f3 = F3_AND; end
      OP_OR:    begin opc = OPC_OP; f3 = F3_OR; end
      OP_XOR:   begin opc = OPC_OP; f3 = F3_XOR; end
      OP_SLL:   begin opc = OPC_OP; f3 = F3_SLL; end
      OP_SRL:   begin opc = OPC_OP; f3 = F3_SRL_SRA; end
      OP_SRA:   begin opc = OPC_OP; f3 = F3_SRL_SRA; f7 = F7_ALT; end
      OP_ADDI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_ADD_SUB; end
      OP_ANDI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_AND; end
      OP_ORI:   begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_OR; end
      OP_XORI:  begin fmt = FMT_I; opc = OPC_OP_IMM; f3 = F3_XOR; end
      OP_LW:    begin fmt = FMT_I; opc = OPC_LOAD;   f3 = F3_LW; end
      OP_SW:    begin fmt = FMT_S; opc = OPC_STORE;  f3 = F3_SW; end
      OP_BEQ:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ; end
      OP_BNE:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE; end
      OP_LUI:   begin fmt = FMT_U; opc = OPC_LUI; end
      OP_AUIPC: begin fmt = FMT_U; opc = OPC_AUIPC; end
      OP_JAL:   begin fmt = FMT_J; opc = OPC_JAL; end
      OP_JALR:  begin fmt = FMT_I; opc = OPC_JALR;   f3 = F3_JALR; end
      default:  op_known = 1'b0;
    endcase
  end

  // Assemble the instruction word and validate the immediate per format
  always_comb begin
    word   = '0;
    imm_ok = 1'b1;
    case (fmt)
      FMT_R: word = {f7, i_rs2, i_rs1, f3, i_rd, opc};
      FMT_I: begin
        word   = {i_imm[11:0], i_rs1, f3, i_rd, opc};
        imm_ok = fit12;
      end
      FMT_S: begin
        word   = {i_imm[11:5], i_rs2, i_rs1, f3, i_imm[4:0], opc};
        imm_ok = fit12;
      end
      FMT_B: begin
        word   = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, f3,
                  i_imm[4:1], i_imm[11], opc};
        imm_ok = fit13 && !i_imm[0];
      end
      FMT_U: begin
        word   = {i_imm[31:12], i_rd, opc};
        imm_ok = (i_imm[11:0] == 12'h000);
      end
      FMT_J: begin
        word   = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, opc};
        imm_ok = fit21 && !i_imm[0];
      end
      default: imm_ok = 1'b0;
    endcase
  end

  assign legal  = op_known && imm_ok;
  assign accept = i_valid && o_ready;
  // Flush drops any concurrent request and any concurrent write
  assign push   = accept && legal && !i_flush;
  assign pop    = o_wr_en && i_wr_ready && !i_flush;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (i_flush),
    .i_push  (push),
    .i_wdata (word),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_count)
  );

  assign o_ready   = !fifo_full;
  assign o_wr_en   = !fifo_empty;
  // Present zero when nothing is queued so the bus is clean after reset
  assign o_wr_data = o_wr_en ? fifo_rdata : 32'h0;
  assign o_wr_addr = wr_addr_q;
  assign o_err     = err_q;

  // Masking keeps the full base port in use while forcing word alignment
  assign base_aligned = i_base & ~ADDR_W'(3);

  // Next write address and sticky error flag
  always_comb begin
    wr_addr_d = wr_addr_q;
    err_d     = err_q;
    if (i_flush) begin
      wr_addr_d = base_aligned;
      err_d     = 1'b0;
    end else begin
      if (pop)              wr_addr_d = wr_addr_q + ADDR_W'(4);
      if (accept && !legal) err_d     = 1'b1;
    end
  end

  // Address and error registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_addr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
    end
  end

endmodule : instr_encoder
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed self-checking bench for instr_encoder with a
//               scoreboard of expected IMEM words and an address model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_valid = 1'b0;
  logic              o_ready;
  logic [4:0]        i_op = '0;
  logic [4:0]        i_rd = '0;
  logic [4:0]        i_rs1 = '0;
  logic [4:0]        i_rs2 = '0;
  logic [31:0]       i_imm = '0;
  logic [ADDR_W-1:0] i_base = '0;
  logic              i_flush = 1'b0;
  logic              o_wr_en;
  logic              i_wr_ready = 1'b1;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [31:0]       o_wr_data;
  logic              o_err;
  logic [2:0]        o_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0]       sb [$];
  logic [ADDR_W-1:0] exp_addr = '0;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_rd       (i_rd),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .i_imm      (i_imm),
    .i_base     (i_base),
    .i_flush    (i_flush),
    .o_wr_en    (o_wr_en),
    .i_wr_ready (i_wr_ready),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_err      (o_err),
    .o_count    (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input logic [4:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
    i_valid = 1'b1;
    i_op    = op;
    i_rd    = rd;
    i_rs1   = rs1;
    i_rs2   = rs2;
    i_imm   = imm;
  endtask

  // Hold the request until a clock edge sees o_ready; record legal words
  task automatic wait_accept(input bit legal, input logic [31:0] word);
    bit done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      if (o_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (done) begin
      if (legal) sb.push_back(word);
    end else begin
      checks++;
      failures++;
      $error("FAIL accept_timeout observed=o_ready_low expected=accept");
    end
    i_valid = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input bit legal,
                      input logic [31:0] word);
    set_req(op, rd, rs1, rs2, imm);
    wait_accept(legal, word);
  endtask

  function automatic logic [31:0] addi_word(input int k);
    return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
  endfunction

  // Write monitor: compare each completed IMEM write against the scoreboard
  always @(negedge clk) begin
    if (i_rst) begin
      exp_addr = '0;
    end else if (i_flush) begin
      exp_addr = {i_base[ADDR_W-1:2], 2'b00};
    end else if (o_wr_en && i_wr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_write observed=0x%08h expected=no_write", o_wr_data);
      end else begin
        logic [31:0] exp_w;
        exp_w = sb.pop_front();
        check("wr_data", o_wr_data, exp_w);
        check("wr_addr", 32'(o_wr_addr), 32'(exp_addr));
        exp_addr = exp_addr + ADDR_W'(4);
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(2);
    check("rst_ready", 32'(o_ready), 32'd1);
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_addr",  32'(o_wr_addr), 32'd0);
    check("rst_data",  o_wr_data, 32'h0);
    check("rst_err",   32'(o_err), 32'd0);
    i_rst = 1'b0;
    tick(1);

    // Basic encodings
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5,  1'b1, 32'h00500093);
    tick(3);
    send(OP_ADD,  5'd3, 5'd1, 5'd2, 32'd0,  1'b1, 32'h002081B3);
    send(OP_SW,   5'd0, 5'd1, 5'd2, 32'd8,  1'b1, 32'h0020A423);
    tick(3);
    send(OP_BEQ,  5'd0, 5'd1, 5'd2, 32'd16, 1'b1, 32'h00208863);
    send(OP_JAL,  5'd1, 5'd0, 5'd0, 32'd8,  1'b1, 32'h008000EF);
    tick(3);

    // Further formats, negative immediates and range edges
    send(OP_SUB,   5'd5, 5'd6, 5'd7, 32'd0,         1'b1, 32'h407302B3);
    send(OP_SRA,   5'd1, 5'd2, 5'd3, 32'd0,         1'b1, 32'h403150B3);
    send(OP_ANDI,  5'd2, 5'd3, 5'd0, 32'hFFFFFFFF,  1'b1, 32'hFFF1F113);
    send(OP_LW,    5'd4, 5'd2, 5'd0, 32'hFFFFFFFC,  1'b1, 32'hFFC12203);
    send(OP_BNE,   5'd0, 5'd1, 5'd0, 32'hFFFFFFF8,  1'b1, 32'hFE009CE3);
    send(OP_AUIPC, 5'd7, 5'd0, 5'd0, 32'hFFFFF000,  1'b1, 32'hFFFFF397);
    send(OP_JALR,  5'd1, 5'd5, 5'd0, 32'd12,        1'b1, 32'h00C280E7);
    send(OP_ADDI,  5'd0, 5'd0, 5'd0, 32'd2047,      1'b1, 32'h7FF00013);
    send(OP_JAL,   5'd0, 5'd0, 5'd0, 32'hFFF00000,  1'b1, 32'h8000006F);
    tick(6);
    check("drain_count", 32'(o_count), 32'd0);
    check("drain_sb", 32'(sb.size()), 32'd0);

    // Illegal requests: accepted, not queued, sticky error
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0);
    check("ill_i_err", 32'(o_err), 32'd1);
    check("ill_i_count", 32'(o_count), 32'd0);
    i_flush = 1'b1; i_base = '0;
    tick(1);
    i_flush = 1'b0;
    check("flush_err", 32'(o_err), 32'd0);
    send(OP_BEQ, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'h0);
    check("ill_b_err", 32'(o_err), 32'd1);
    tick(2);
    check("ill_sticky", 32'(o_err), 32'd1);
    i_flush = 1'b1;
    tick(1);
    i_flush = 1'b0;
    send(5'd20, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0);
    check("ill_op_err", 32'(o_err), 32'd1);
    check("ill_op_wr_en", 32'(o_wr_en), 32'd0);
    i_flush = 1'b1;
    tick(1);
    i_flush = 1'b0;

    // U-type low bits, then flush to top of memory and wrap
    send(OP_LUI, 5'd5, 5'd0, 5'd0, 32'h12345001, 1'b0, 32'h0);
    check("lui_err", 32'(o_err), 32'd1);
    check("lui_wr_en", 32'(o_wr_en), 32'd0);
    i_flush = 1'b1; i_base = 10'h3FC;
    tick(1);
    i_flush = 1'b0;
    sb.delete();
    check("flush2_err", 32'(o_err), 32'd0);
    check("flush2_addr", 32'(o_wr_addr), 32'h3FC);
    send(OP_LUI,  5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7);
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5,        1'b1, 32'h00500093);
    tick(3);
    check("wrap_addr", 32'(o_wr_addr), 32'h004);

    // Back-pressure: fill the FIFO, fifth request stalls, then release
    i_flush = 1'b1; i_base = '0;
    tick(1);
    i_flush = 1'b0;
    i_wr_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(OP_ADDI, 5'(k), 5'd0, 5'd0, 32'(k), 1'b1, addi_word(k));
    check("full_ready", 32'(o_ready), 32'd0);
    check("full_count", 32'(o_count), 32'd4);
    set_req(OP_ADDI, 5'd5, 5'd0, 5'd0, 32'd5);
    tick(3);
    check("stall_ready", 32'(o_ready), 32'd0);
    check("stall_count", 32'(o_count), 32'd4);
    check("stall_data", o_wr_data, addi_word(1));
    check("stall_addr", 32'(o_wr_addr), 32'h000);
    i_wr_ready = 1'b1;
    wait_accept(1'b1, addi_word(5));
    tick(8);
    check("bp_sb", 32'(sb.size()), 32'd0);
    check("bp_addr", 32'(o_wr_addr), 32'h014);

    // Reset with words queued and the write side stalled
    i_wr_ready = 1'b0;
    for (int k = 6; k <= 8; k++) send(OP_ADDI, 5'(k), 5'd0, 5'd0, 32'(k), 1'b1, addi_word(k));
    check("pre_rst_count", 32'(o_count), 32'd3);
    i_rst = 1'b1;
    tick(1);
    sb.delete();
    check("rst2_wr_en", 32'(o_wr_en), 32'd0);
    check("rst2_count", 32'(o_count), 32'd0);
    check("rst2_addr",  32'(o_wr_addr), 32'd0);
    check("rst2_ready", 32'(o_ready), 32'd1);
    i_rst = 1'b0;
    i_wr_ready = 1'b1;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instr_encoder
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, encoded-word FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 10, IMEM byte-address width.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
- i_clk  input  1  sole clock, rising edge.
- i_rst  input  1  synchronous active-high reset.
REQ-004 SHALL have these request-side ports:
- i_valid  input  1  request valid.
- o_ready  output  1  request accepted when i_valid && o_ready.
- i_op  input  5  enc_op_e: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, ADDI, ANDI, ORI, XORI, LW, SW, BEQ, BNE, LUI, AUIPC, JAL, JALR.
- i_rd, i_rs1, i_rs2  input  5 each  register indices.
- i_imm  input  32  signed byte immediate; U-type uses imm[31:12].
- i_base  input  ADDR_W  start address, loaded on i_flush.
- i_flush  input  1  drop FIFO contents, load address, clear o_err.
REQ-005 SHALL have these IMEM write-side ports:
- o_wr_en  output  1  write valid.
- i_wr_ready  input  1  write taken when o_wr_en && i_wr_ready.
- o_wr_addr  output  ADDR_W  word-aligned byte address.
- o_wr_data  output  32  RV32I instruction word.
REQ-006 SHALL have these status ports:
- o_err  output  1  sticky illegal-request flag.
- o_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-007 Each accepted request SHALL be encoded to the RV32I word whose opcode/funct3/funct7 exactly invert the core decoder table: R 0110011, I-ALU 0010011, LW 0000011/f3=010, SW 0100011/f3=010, BEQ/BNE 1100011/f3=000/001, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111/f3=000.
REQ-008 Immediate placement SHALL follow I/S/B/U/J formats; unused fields (rs2 for I, rd for S/B) SHALL be zero.
REQ-009 A request SHALL be illegal when i_op is outside enc_op_e, or when I/S imm lies outside [-2048,2047], B imm outside [-4096,4094] or is odd, J imm outside [-2^20, 2^20-2] or is odd, or U imm[11:0] != 0.
REQ-010 An illegal request SHALL still be accepted (handshake completes), SHALL NOT be pushed, and SHALL set o_err=1 from the next cycle until reset or i_flush.
REQ-011 o_ready SHALL equal !full, registered-independent of i_valid; a push while full SHALL never occur.
REQ-012 Encoding SHALL be combinational into the FIFO write port; a word accepted at edge N SHALL be visible on o_wr_en/o_wr_data at cycle N+1 at the earliest.
REQ-013 FIFO SHALL be first-in first-out; simultaneous push and pop SHALL be allowed when neither empty nor full, leaving o_count unchanged.
REQ-014 o_wr_en SHALL equal !empty; o_wr_data/o_wr_addr SHALL hold stable while o_wr_en && !i_wr_ready.
REQ-015 o_wr_addr SHALL advance by 4 after each completed write and wrap modulo 2^ADDR_W; bits [1:0] SHALL always be 0.
REQ-016 i_flush SHALL take priority over push and pop in the same cycle: the FIFO empties, o_wr_addr loads {i_base[ADDR_W-1:2],2'b00}, o_err clears, the concurrent request is not pushed.

Reset
REQ-017 On i_rst: FIFO empty, o_count=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_err=0, o_ready=1; reset SHALL override flush and any in-flight handshake.

Structure
REQ-018 enc_op_e, opcode and funct3/funct7 constants SHALL live in the shared define package alongside the existing decoder constants.
REQ-019 Buffering SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH); encoding and range checks stay in instr_encoder.

Verification
REQ-020 ADDI rd=1 rs1=0 imm=5 after reset -> o_wr_data=0x00500093 at o_wr_addr=0x000.
REQ-021 ADD rd=3 rs1=1 rs2=2, then SW rs1=1 rs2=2 imm=8 -> 0x002081B3 at 0x000, then 0x0020A423 at 0x004.
REQ-022 BEQ rs1=1 rs2=2 imm=16, then JAL rd=1 imm=8 -> 0x00208863, then 0x008000EF.
REQ-023 Hold i_wr_ready=0 and push 5 words with DEPTH=4 -> o_ready=0 after 4th, o_count=4, 5th waits; release -> 5 writes in order at consecutive addresses.
REQ-024 LUI imm=0x12345001 -> no write, o_err=1; then i_flush with i_base=0x3FC -> o_err=0; LUI rd=5 imm=0x12345000 written as 0x123452B7 at 0x3FC, next write at 0x000 (wrap).
REQ-025 i_rst asserted with 3 words queued and i_wr_ready=0 -> next cycle o_wr_en=0, o_count=0, o_wr_addr=0.
